// File: rtl/ff_reset_sequencer.sv
// ff_reset_sequencer: reset and clock-enable sequencer for the flip-flop test banks.
// Walks the bank through asynchronous reset, synchronous-reset hold, settle and run.
// Once the bank is running, it also handles soft-reset requests and clock pausing.
// Optional feature macro: FF_RST_SEQ_COUNT_EN adds the saturating o_reset_count port,
// which counts completed soft resets.
module ff_reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 2,
  parameter int GATE_CYCLES     = 3
) (
  input  logic       clk,
  input  logic       async_reset,
  input  logic       soft_reset_req,
  input  logic       gate_req,
  output logic       o_async_reset,
  output logic       o_async_reset_n,
  output logic       o_sync_reset,
  output logic       o_clk_enable,
  output logic       o_ready,
  output logic       o_busy
`ifdef FF_RST_SEQ_COUNT_EN
  ,
  output logic [7:0] o_reset_count
`endif
);

  localparam int MAX_AB  = (RST_HOLD_CYCLES > SETTLE_CYCLES) ? RST_HOLD_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > GATE_CYCLES) ? MAX_AB : GATE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_PAUSE  = 3'd4;
  localparam logic [2:0] S_GATE   = 3'd5;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Next-state logic: one shared down-counter is loaded with N-1 on entry to each timed state
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET: begin
        if (sync_q[SYNC_STAGES-1]) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RUN: begin
        if (soft_reset_req) begin
          state_d = S_GATE;
          cnt_d   = GATE_LOAD;
        end else if (gate_req) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (soft_reset_req) begin
          state_d = S_GATE;
          cnt_d   = GATE_LOAD;
        end else if (!gate_req) begin
          state_d = S_RUN;
        end
      end
      S_GATE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // State, synchronizer and counter registers; async_reset takes effect without a clock
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      sync_q  <= '0;
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FF_RST_SEQ_COUNT_EN
  logic [7:0] reset_count_q, reset_count_d;

  // Soft-reset counter: counts completed gate phases and saturates at 255
  always_comb begin
    reset_count_d = reset_count_q;
    if ((state_q == S_GATE) && (state_d == S_HOLD) && (reset_count_q != 8'hFF)) begin
      reset_count_d = reset_count_q + 8'd1;
    end
  end

  // Soft-reset counter register, cleared only by async_reset
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      reset_count_q <= '0;
    end else begin
      reset_count_q <= reset_count_d;
    end
  end

  assign o_reset_count = reset_count_q;
`endif

  // Moore output decode of the registered state
  always_comb begin
    o_async_reset = 1'b0;
    o_sync_reset  = 1'b0;
    o_clk_enable  = 1'b0;
    o_ready       = 1'b0;
    o_busy        = 1'b0;
    case (state_q)
      S_RESET: begin
        o_async_reset = 1'b1;
        o_sync_reset  = 1'b1;
        o_busy        = 1'b1;
      end
      S_HOLD: begin
        o_sync_reset = 1'b1;
        o_clk_enable = 1'b1;
        o_busy       = 1'b1;
      end
      S_SETTLE: begin
        o_clk_enable = 1'b1;
        o_busy       = 1'b1;
      end
      S_RUN: begin
        o_clk_enable = 1'b1;
        o_ready      = 1'b1;
      end
      S_PAUSE: begin
        o_clk_enable = 1'b0;
      end
      S_GATE: begin
        o_sync_reset = 1'b1;
        o_busy       = 1'b1;
      end
      default: begin
        o_async_reset = 1'b1;
        o_sync_reset  = 1'b1;
        o_busy        = 1'b1;
      end
    endcase
  end

  assign o_async_reset_n = ~o_async_reset;

endmodule

// File: tb/tb_ff_reset_sequencer.sv
// Directed testbench for ff_reset_sequencer with the default parameters (2/4/2/3).
// Output vector order: {o_async_reset, o_async_reset_n, o_sync_reset, o_clk_enable, o_ready, o_busy}.
module tb_ff_reset_sequencer;

  logic       clk = 1'b0;
  logic       async_reset = 1'b1;
  logic       soft_reset_req = 1'b0;
  logic       gate_req = 1'b0;
  logic       o_async_reset, o_async_reset_n, o_sync_reset, o_clk_enable, o_ready, o_busy;
  logic [5:0] outs;
  logic [5:0] exp_v;
  int         errors = 0;
  int         checks = 0;
`ifdef FF_RST_SEQ_COUNT_EN
  logic [7:0] o_reset_count;
  int         exp_count = 0;
`endif

  localparam logic [5:0] V_RESET  = 6'b101001;
  localparam logic [5:0] V_HOLD   = 6'b011101;
  localparam logic [5:0] V_SETTLE = 6'b010101;
  localparam logic [5:0] V_RUN    = 6'b010110;
  localparam logic [5:0] V_PAUSE  = 6'b010000;
  localparam logic [5:0] V_GATE   = 6'b011001;

  ff_reset_sequencer #(
    .SYNC_STAGES    (2),
    .RST_HOLD_CYCLES(4),
    .SETTLE_CYCLES  (2),
    .GATE_CYCLES    (3)
  ) dut (
    .clk            (clk),
    .async_reset    (async_reset),
    .soft_reset_req (soft_reset_req),
    .gate_req       (gate_req),
    .o_async_reset  (o_async_reset),
    .o_async_reset_n(o_async_reset_n),
    .o_sync_reset   (o_sync_reset),
    .o_clk_enable   (o_clk_enable),
    .o_ready        (o_ready),
    .o_busy         (o_busy)
`ifdef FF_RST_SEQ_COUNT_EN
    ,
    .o_reset_count  (o_reset_count)
`endif
  );

  assign outs = {o_async_reset, o_async_reset_n, o_sync_reset, o_clk_enable, o_ready, o_busy};

  always #5 clk = ~clk;

  // Expected outputs after edge e of a power-up (edge 1 = first edge with reset low)
  function automatic logic [5:0] exp_bringup(input int e);
    if (e <= 2) return V_RESET;
    else if (e <= 6) return V_HOLD;
    else if (e <= 8) return V_SETTLE;
    else return V_RUN;
  endfunction

  // Expected outputs j edges after the edge that sampled a soft reset request
  function automatic logic [5:0] exp_soft(input int j);
    if (j <= 2) return V_GATE;
    else if (j <= 6) return V_HOLD;
    else if (j <= 8) return V_SETTLE;
    else return V_RUN;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    async_reset = 1'b1;
    repeat (5) step();
    checks++;
    if (outs !== V_RESET) begin
      errors++;
      $display("FAIL reset_values got=%b exp=%b", outs, V_RESET);
    end
`ifdef FF_RST_SEQ_COUNT_EN
    checks++;
    if (o_reset_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d exp=0", o_reset_count);
    end
`endif
  endtask

  task automatic test_powerup();
    async_reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp_v = exp_bringup(e);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL powerup_edge%0d got=%b exp=%b", e, outs, exp_v);
      end
    end
  endtask

  task automatic test_soft_reset();
    soft_reset_req = 1'b1;
    step();
    soft_reset_req = 1'b0;
    for (int j = 0; j <= 9; j++) begin
      if (j > 0) step();
      exp_v = exp_soft(j);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL soft_reset_k+%0d got=%b exp=%b", j, outs, exp_v);
      end
    end
`ifdef FF_RST_SEQ_COUNT_EN
    exp_count++;
    checks++;
    if (o_reset_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL soft_reset_count got=%0d exp=%0d", o_reset_count, exp_count);
    end
`endif
  endtask

  task automatic test_pause();
    gate_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (outs !== V_PAUSE) begin
        errors++;
        $display("FAIL pause_cycle%0d got=%b exp=%b", i, outs, V_PAUSE);
      end
    end
    gate_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs !== V_RUN) begin
        errors++;
        $display("FAIL pause_resume%0d got=%b exp=%b", i, outs, V_RUN);
      end
    end
  endtask

  task automatic test_priority();
    soft_reset_req = 1'b1;
    gate_req       = 1'b1;
    step();
    soft_reset_req = 1'b0;
    // gate_req stays high: ignored until RUN, then pauses on the following edge
    for (int j = 0; j <= 9; j++) begin
      if (j > 0) step();
      exp_v = exp_soft(j);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL priority_k+%0d got=%b exp=%b", j, outs, exp_v);
      end
    end
    step();
    checks++;
    if (outs !== V_PAUSE) begin
      errors++;
      $display("FAIL priority_late_pause got=%b exp=%b", outs, V_PAUSE);
    end
    gate_req = 1'b0;
    step();
    checks++;
    if (outs !== V_RUN) begin
      errors++;
      $display("FAIL priority_resume got=%b exp=%b", outs, V_RUN);
    end
`ifdef FF_RST_SEQ_COUNT_EN
    exp_count++;
`endif
  endtask

  task automatic test_back_to_back();
    gate_req = 1'b1;
    step();
    checks++;
    if (outs !== V_PAUSE) begin
      errors++;
      $display("FAIL b2b_pause got=%b exp=%b", outs, V_PAUSE);
    end
    for (int r = 0; r < 2; r++) begin
      soft_reset_req = 1'b1;
      step();
      soft_reset_req = 1'b0;
      gate_req       = 1'b0;
      for (int j = 0; j <= 9; j++) begin
        if (j > 0) step();
        exp_v = exp_soft(j);
        checks++;
        if (outs !== exp_v) begin
          errors++;
          $display("FAIL b2b_r%0d_k+%0d got=%b exp=%b", r, j, outs, exp_v);
        end
      end
    end
`ifdef FF_RST_SEQ_COUNT_EN
    exp_count += 2;
    checks++;
    if (o_reset_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=%0d", o_reset_count, exp_count);
    end
`endif
  endtask

  task automatic test_mid_reset();
    soft_reset_req = 1'b1;
    step();
    soft_reset_req = 1'b0;
    repeat (3) step();
    checks++;
    if (outs !== V_HOLD) begin
      errors++;
      $display("FAIL mid_pre_hold got=%b exp=%b", outs, V_HOLD);
    end
    #2 async_reset = 1'b1;
    #1;
    checks++;
    if (outs !== V_RESET) begin
      errors++;
      $display("FAIL mid_immediate got=%b exp=%b", outs, V_RESET);
    end
    #2 async_reset = 1'b0;
    // soft reset requested while settling must be dropped
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 8) soft_reset_req = 1'b0;
      exp_v = exp_bringup(e);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL mid_restart_edge%0d got=%b exp=%b", e, outs, exp_v);
      end
      if (e == 7) soft_reset_req = 1'b1;
    end
`ifdef FF_RST_SEQ_COUNT_EN
    exp_count = 0;
    checks++;
    if (o_reset_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL mid_count got=%0d exp=%0d", o_reset_count, exp_count);
    end
`endif
  endtask

`ifdef FF_RST_SEQ_COUNT_EN
  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      soft_reset_req = 1'b1;
      step();
      soft_reset_req = 1'b0;
      repeat (9) step();
    end
    exp_count = (exp_count + 260 > 255) ? 255 : exp_count + 260;
    checks++;
    if (o_reset_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL saturation_count got=%0d exp=%0d", o_reset_count, exp_count);
    end
    checks++;
    if (outs !== V_RUN) begin
      errors++;
      $display("FAIL saturation_run got=%b exp=%b", outs, V_RUN);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_powerup();
    test_soft_reset();
    test_pause();
    test_priority();
    test_back_to_back();
    test_mid_reset();
`ifdef FF_RST_SEQ_COUNT_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
